// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one word at a time over
// a req/ack memory handshake, and holds it for the decoder until execute retires it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    // Memory side: imem_req stays high with imem_addr frozen until the cycle in which
    // imem_ack=1; that cycle completes the transfer and imem_rdata is captured.
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [25:0] TargetInstr,
    input  logic [15:0] Imm16,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        take_branch;
    logic        fetch_done;
    logic        retire_now;
    logic        unused_reg_bits;

    assign fetch_done = (state == ST_REQ) && imem_ack;
    assign retire_now = (state == ST_ISSUE) && retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_RST: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (retire) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_RST;
            end
        endcase
    end

    // PC only moves at retire; the captured word only changes when a fetch completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (retire_now) begin
            pc_r <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_r <= 32'h0;
        end else if (fetch_done) begin
            instr_r <= imem_rdata;
        end
    end

    assign pc_plus4      = pc_r + 32'd4;
    assign branch_offset = {{14{Imm16[15]}}, Imm16, 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign jump_target   = {pc_plus4[31:28], TargetInstr, 2'b00};
    assign jr_target     = {reg_target[31:2], 2'b00};
    assign take_branch   = Branch && Zero;

    // Register jump beats absolute jump beats taken branch beats fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = jr_target;
        end else if (Jump) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end

    assign unused_reg_bits = ^reg_target[1:0];

    assign pc        = pc_r;
    assign imem_addr = pc_r;
    assign instr     = instr_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory/retire driver pushes expected
// fetch addresses and words into queues; a negedge monitor pops and compares them.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        retire;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic        JumpReg;
    logic [25:0] TargetInstr;
    logic [15:0] Imm16;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic        valid_d = 1'b0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .retire(retire),
        .Branch(Branch), .Zero(Zero), .Jump(Jump), .JumpReg(JumpReg),
        .TargetInstr(TargetInstr), .Imm16(Imm16), .reg_target(reg_target),
        .pc(pc), .pc_plus4(pc_plus4), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int waits);
        int t = 0;
        while (!imem_req && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!imem_req) begin
            chk("req_timeout", {31'h0, imem_req}, 32'h1);
            return;
        end
        exp_addr_q.push_back(exp_addr);
        exp_instr_q.push_back(data);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, exp_addr);
            chk("wait_valid", {31'h0, instr_valid}, 32'h0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid_after_ack", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic do_retire(input logic br, input logic zr, input logic jp, input logic jr,
                             input logic [25:0] ti, input logic [15:0] imm, input logic [31:0] rt);
        int t = 0;
        while (!instr_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!instr_valid) begin
            chk("valid_timeout", {31'h0, instr_valid}, 32'h1);
            return;
        end
        Branch = br; Zero = zr; Jump = jp; JumpReg = jr;
        TargetInstr = ti; Imm16 = imm; reg_target = rt;
        retire = 1'b1;
        @(posedge clk); #1;
        retire = 1'b0;
        Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        TargetInstr = '0; Imm16 = '0; reg_target = '0;
        chk("req_after_retire", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic plain_retire();
        do_retire(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && imem_req && imem_ack) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (!reset && instr_valid && !valid_d) begin
            if (exp_instr_q.size() == 0) begin
                chk("unexpected_issue", instr, 32'hFFFF_FFFF);
            end else begin
                chk("issued_instr", instr, exp_instr_q.pop_front());
            end
        end
        valid_d = instr_valid;
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; retire = 1'b0;
        Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        TargetInstr = '0; Imm16 = '0; reg_target = '0;

        // 1: reset for two cycles, then release
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_req", {31'h0, imem_req}, 32'h0);
        end
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_state", {30'h0, dbg_state}, 32'h0);
        reset = 1'b0;
        chk("rel_req_low", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("rel_req_high", {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        // 2: zero-wait sequential fetch
        fetch(32'h0000_0000, 32'hA000_0000, 0); plain_retire();
        fetch(32'h0000_0004, 32'hA000_0004, 0); plain_retire();
        fetch(32'h0000_0008, 32'hA000_0008, 0); plain_retire();
        fetch(32'h0000_000C, 32'hA000_000C, 0); plain_retire();

        // 3: branch taken backwards, then not taken
        fetch(32'h0000_0010, 32'hB000_0010, 0);
        chk("link_value", pc_plus4, 32'h0000_0014);
        do_retire(1'b1, 1'b1, 1'b0, 1'b0, 26'h0, 16'hFFFE, 32'h0);
        fetch(32'h0000_000C, 32'hB000_000C, 0); plain_retire();
        fetch(32'h0000_0010, 32'hB100_0010, 0);
        do_retire(1'b1, 1'b0, 1'b0, 1'b0, 26'h0, 16'hFFFE, 32'h0);
        fetch(32'h0000_0014, 32'hB000_0014, 0);
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 16'h0, 32'h0000_0013);

        // 4: absolute jump, then JumpReg beating Jump
        fetch(32'h0000_0010, 32'hC000_0010, 0);
        do_retire(1'b0, 1'b0, 1'b1, 1'b0, 26'h40, 16'h0, 32'h0);

        // 5: three wait states, stray ack in ISSUE, stray retire in REQ
        fetch(32'h0000_0100, 32'hD000_0100, 3);
        do_retire(1'b1, 1'b1, 1'b1, 1'b1, 26'h40, 16'h0004, 32'h0000_2003);
        fetch(32'h0000_2000, 32'hD000_2000, 0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("stray_ack_instr", instr, 32'hD000_2000);
        chk("stray_ack_valid", {31'h0, instr_valid}, 32'h1);
        chk("stray_ack_pc", pc, 32'h0000_2000);
        plain_retire();
        retire = 1'b1; Jump = 1'b1; TargetInstr = 26'h3FF_FFFF;
        @(posedge clk); #1;
        retire = 1'b0; Jump = 1'b0; TargetInstr = '0;
        chk("stray_ret_req", {31'h0, imem_req}, 32'h1);
        chk("stray_ret_addr", imem_addr, 32'h0000_2004);
        chk("stray_ret_valid", {31'h0, instr_valid}, 32'h0);
        fetch(32'h0000_2004, 32'hD000_2004, 1);

        // 6: wrap at top of address space
        do_retire(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 16'h0, 32'hFFFF_FFFE);
        fetch(32'hFFFF_FFFC, 32'hE000_FFFC, 0);
        chk("wrap_plus4", pc_plus4, 32'h0);
        plain_retire();
        fetch(32'h0000_0000, 32'hE000_0000, 0);
        plain_retire();

        // 6: reset while REQ is pending, ack arriving right after reset
        chk("pre_rst_addr", imem_addr, 32'h0000_0004);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("post_rst_instr", instr, 32'h0);
        fetch(32'h0000_0000, 32'hF000_0000, 0);
        plain_retire();

        @(negedge clk);
        chk("addr_q_drained", exp_addr_q.size(), 32'h0);
        chk("instr_q_drained", exp_instr_q.size(), 32'h0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
